// File: rtl/spy_path_sequencer.sv
// spy_path_sequencer: launches, captures and scores timing trials on an external inverting spy delay chain.
// Build option: define SPY_SETTLE_CHECK_EN to add the settled-value fault counter on o_fault_count.
//
// state   | meaning
// IDLE    | waiting for an accepted start
// LAUNCH  | toggle chain drive, record expected level
// CAPTURE | one-period timing capture of chain output
// SETTLE  | score the trial, wait settle_cycles, advance trial
// DONE    | result held until consumer accepts
module spy_path_sequencer #(
    parameter int TRIALS_W      = 16,
    parameter int CNT_W         = 16,
    parameter int SETTLE_W      = 8,
    parameter bit EXPECT_INVERT = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [TRIALS_W-1:0] i_trials,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
    output logic                o_path_drive,
    input  logic                i_path_sample,
    output logic                o_busy,
    output logic                o_result_valid,
    input  logic                i_result_ready,
    output logic [CNT_W-1:0]    o_late_count,
    output logic [CNT_W-1:0]    o_fault_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CAPTURE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TRIALS_W-1:0] r_trials_lat;
    logic [TRIALS_W-1:0] r_trial_cnt;
    logic [TRIALS_W-1:0] w_trial_inc;
    logic [SETTLE_W-1:0] r_settle_lat;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_drive;
    logic                r_exp;
    logic                r_cap;
    logic [CNT_W-1:0]    r_late_cnt;
    logic                w_accept;
    logic                w_first_settle;
    logic                w_last_settle;
    logic                w_late_miss;

    assign w_accept       = (r_state == S_IDLE) && i_start;
    assign w_first_settle = (r_state == S_SETTLE) && (r_settle_cnt == r_settle_lat);
    assign w_last_settle  = (r_state == S_SETTLE) && (r_settle_cnt == '0);
    // r_cap has a full clock period to resolve before it is scored here
    assign w_late_miss    = r_cap ^ r_exp;

    always_comb begin
        w_state_nxt = r_state;
        w_trial_inc = r_trial_cnt + TRIALS_W'(1);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_trials != '0) ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = (w_trial_inc == r_trials_lat) ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                if (i_result_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_trials_lat <= '0;
            r_trial_cnt  <= '0;
            r_settle_lat <= '0;
            r_settle_cnt <= '0;
            r_drive      <= 1'b0;
            r_exp        <= 1'b0;
            r_cap        <= 1'b0;
            r_late_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_trials_lat <= i_trials;
                        r_settle_lat <= i_settle_cycles;
                        r_trial_cnt  <= '0;
                        r_late_cnt   <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_drive <= ~r_drive;
                    r_exp   <= ~r_drive ^ EXPECT_INVERT;
                end
                S_CAPTURE: begin
                    r_cap        <= i_path_sample;
                    r_settle_cnt <= r_settle_lat;
                end
                S_SETTLE: begin
`ifdef SPY_SETTLE_CHECK_EN
                    r_cap <= i_path_sample;
`endif
                    if (w_first_settle && w_late_miss && (r_late_cnt != CNT_MAX)) begin
                        r_late_cnt <= r_late_cnt + CNT_W'(1);
                    end
                    if (r_settle_cnt == '0) begin
                        r_trial_cnt <= w_trial_inc;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPY_SETTLE_CHECK_EN
    logic             r_res;
    logic [CNT_W-1:0] r_fault_cnt;

    // r_cap keeps re-sampling through SETTLE, so r_res on the last cycle is a settled chain level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res       <= 1'b0;
            r_fault_cnt <= '0;
        end else begin
            r_res <= r_cap;
            if (w_accept) begin
                r_fault_cnt <= '0;
            end else if (w_last_settle && (r_res != r_exp) && (r_fault_cnt != CNT_MAX)) begin
                r_fault_cnt <= r_fault_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fault_count = r_fault_cnt;
`else
    assign o_fault_count = '0;
`endif

    assign o_path_drive   = r_drive;
    assign o_busy         = (r_state != S_IDLE);
    assign o_result_valid = (r_state == S_DONE);
    assign o_late_count   = r_late_cnt;

endmodule

// File: tb/tb_spy_path_sequencer.sv
// Self-checking bench for spy_path_sequencer: delay-chain model plus a trial-level reference model.
`timescale 1ns/1ps
module tb_spy_path_sequencer;

    localparam int TRIALS_W   = 16;
    localparam int CNT_W      = 16;
    localparam int SETTLE_W   = 8;
    localparam bit INV        = 1'b0;
    localparam int S_TRIALS_W = 3;
    localparam int S_CNT_W    = 2;
    localparam int BUDGET     = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start;
    logic [TRIALS_W-1:0] trials;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                path_drive;
    logic                path_sample;
    logic                busy;
    logic                result_valid;
    logic                result_ready;
    logic [CNT_W-1:0]    late_count;
    logic [CNT_W-1:0]    fault_count;

    logic                  s_start;
    logic [S_TRIALS_W-1:0] s_trials;
    logic [SETTLE_W-1:0]   s_settle;
    logic                  s_drive;
    logic                  s_sample;
    logic                  s_busy;
    logic                  s_valid;
    logic                  s_ready;
    logic [S_CNT_W-1:0]    s_late;
    logic [S_CNT_W-1:0]    s_fault;

    int n_cmp = 0;
    int n_bad = 0;
    bit drv_model;
    bit s_drv_model;

    // transport-delay chain models; chain output = drive ^ polarity after the delay
    int   chain_dly = 3;
    logic chain_out = 1'b0;
    logic stuck_en  = 1'b0;
    logic stuck_val = 1'b0;
    always @(path_drive) chain_out <= #(chain_dly) (path_drive ^ INV);
    assign path_sample = stuck_en ? stuck_val : chain_out;

    logic s_chain = 1'b0;
    always @(s_drive) s_chain <= #14 (s_drive ^ INV);
    assign s_sample = s_chain;

    spy_path_sequencer #(
        .TRIALS_W(TRIALS_W), .CNT_W(CNT_W), .SETTLE_W(SETTLE_W), .EXPECT_INVERT(INV)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_trials(trials),
        .i_settle_cycles(settle_cycles), .o_path_drive(path_drive),
        .i_path_sample(path_sample), .o_busy(busy), .o_result_valid(result_valid),
        .i_result_ready(result_ready), .o_late_count(late_count), .o_fault_count(fault_count)
    );

    spy_path_sequencer #(
        .TRIALS_W(S_TRIALS_W), .CNT_W(S_CNT_W), .SETTLE_W(SETTLE_W), .EXPECT_INVERT(INV)
    ) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_trials(s_trials),
        .i_settle_cycles(s_settle), .o_path_drive(s_drive),
        .i_path_sample(s_sample), .o_busy(s_busy), .o_result_valid(s_valid),
        .i_result_ready(s_ready), .o_late_count(s_late), .o_fault_count(s_fault)
    );

    // Trial-level model: launch at t=0, timing capture at t=10ns, settled look at t=10*s ns.
    function automatic void model_trials(input int n, input int s, input int d, input bit stk,
                                         input bit sv, input bit p0, output int late, output int fault);
        bit lvl;
        bit expv;
        bit capv;
        bit setv;
        lvl   = p0;
        late  = 0;
        fault = 0;
        for (int k = 0; k < n; k++) begin
            lvl  = ~lvl;
            expv = lvl ^ INV;
            capv = stk ? sv : ((d < 10) ? expv : ~expv);
            setv = stk ? sv : ((d < 10 * s) ? expv : ~expv);
            if (capv != expv) late++;
            if (setv != expv) fault++;
        end
    endfunction

    function automatic int sat(input int v, input int cmax);
        return (v > cmax) ? cmax : v;
    endfunction

    // expected fault count; the settled check is only meaningful with at least one settle cycle
    function automatic void fault_expect(input int s, input int fm, input int cmax,
                                         output bit chk, output int ef);
`ifdef SPY_SETTLE_CHECK_EN
        chk = (s >= 1);
        ef  = sat(fm, cmax);
`else
        chk = 1'b1;
        ef  = 0;
`endif
    endfunction

    task automatic do_run(input int n, input int s, output int cycles, output int toggles,
                          output bit timed_out);
        bit prev;
        @(negedge clk);
        trials        = TRIALS_W'(n);
        settle_cycles = SETTLE_W'(s);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        prev      = path_drive;
        cycles    = 0;
        toggles   = 0;
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (path_drive !== prev) toggles++;
            prev = path_drive;
            if (result_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_accept();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; result_ready = 1'b0; trials = '0; settle_cycles = '0;
        s_start = 1'b0; s_ready = 1'b0; s_trials = '0; s_settle = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_cmp++; if (path_drive !== 1'b0) begin n_bad++; $display("FAIL reset_drive: got %b want 0", path_drive); end
        n_cmp++; if (late_count !== '0) begin n_bad++; $display("FAIL reset_late: got %0d want 0", late_count); end
        n_cmp++; if (fault_count !== '0) begin n_bad++; $display("FAIL reset_fault: got %0d want 0", fault_count); end
        n_cmp++; if (s_busy !== 1'b0 || s_late !== '0) begin n_bad++; $display("FAIL reset_small: busy %b late %0d want 0/0", s_busy, s_late); end
        @(negedge clk);
        rst = 1'b0;
        drv_model   = 1'b0;
        s_drv_model = 1'b0;
    endtask

    task automatic test_fast_chain();
        int cyc, tog, lm, fm, ef;
        bit to, chk;
        chain_dly = 3; stuck_en = 1'b0;
        model_trials(10, 4, 3, 1'b0, 1'b0, drv_model, lm, fm);
        fault_expect(4, fm, 65535, chk, ef);
        do_run(10, 4, cyc, tog, to);
        drv_model = drv_model ^ 1'b0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL fast_timeout: no result_valid within %0d cycles", BUDGET); end
        n_cmp++; if (cyc != 70) begin n_bad++; $display("FAIL fast_latency: got %0d cycles want 70", cyc); end
        n_cmp++; if (late_count !== CNT_W'(lm)) begin n_bad++; $display("FAIL fast_late: got %0d want %0d", late_count, lm); end
        n_cmp++; if (tog != 10) begin n_bad++; $display("FAIL fast_toggles: got %0d want 10", tog); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fast_busy_done: got %b want 1", busy); end
        if (chk) begin
            n_cmp++; if (fault_count !== CNT_W'(ef)) begin n_bad++; $display("FAIL fast_fault: got %0d want %0d", fault_count, ef); end
        end
        do_accept();
        n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL fast_accept: valid %b busy %b want 0/0", result_valid, busy); end
        n_cmp++; if (late_count !== CNT_W'(lm)) begin n_bad++; $display("FAIL fast_late_held: got %0d want %0d", late_count, lm); end
    endtask

    task automatic test_slow_chain();
        int cyc, tog, lm, fm, ef;
        bit to, chk;
        chain_dly = 14; stuck_en = 1'b0;
        model_trials(8, 2, 14, 1'b0, 1'b0, drv_model, lm, fm);
        fault_expect(2, fm, 65535, chk, ef);
        do_run(8, 2, cyc, tog, to);
        n_cmp++; if (to || cyc != 40) begin n_bad++; $display("FAIL slow_latency: got %0d cycles (timeout %b) want 40", cyc, to); end
        n_cmp++; if (late_count !== CNT_W'(lm) || lm != 8) begin n_bad++; $display("FAIL slow_late: got %0d want %0d", late_count, lm); end
        if (chk) begin
            n_cmp++; if (fault_count !== CNT_W'(ef)) begin n_bad++; $display("FAIL slow_fault: got %0d want %0d", fault_count, ef); end
        end
        do_accept();
    endtask

    task automatic test_stuck();
        int cyc, tog, lm, fm, ef;
        bit to, chk;
        stuck_en = 1'b1; stuck_val = 1'b0;
        model_trials(6, 3, 3, 1'b1, 1'b0, drv_model, lm, fm);
        fault_expect(3, fm, 65535, chk, ef);
        do_run(6, 3, cyc, tog, to);
        n_cmp++; if (to || cyc != 36) begin n_bad++; $display("FAIL stuck_latency: got %0d cycles want 36", cyc); end
        n_cmp++; if (late_count !== CNT_W'(lm)) begin n_bad++; $display("FAIL stuck_late: got %0d want %0d", late_count, lm); end
        if (chk) begin
            n_cmp++; if (fault_count !== CNT_W'(ef)) begin n_bad++; $display("FAIL stuck_fault: got %0d want %0d", fault_count, ef); end
        end
        do_accept();
        stuck_en = 1'b0;
    endtask

    task automatic test_zero_trials();
        bit drv0;
        @(negedge clk);
        trials = '0; settle_cycles = SETTLE_W'(3); start = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (result_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL zero_done: valid %b busy %b want 1/1", result_valid, busy); end
        n_cmp++; if (late_count !== '0) begin n_bad++; $display("FAIL zero_late: got %0d want 0", late_count); end
        drv0   = path_drive;
        trials = TRIALS_W'(5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (result_valid !== 1'b1 || late_count !== '0 || path_drive !== drv0) begin
                n_bad++;
                $display("FAIL zero_hold[%0d]: valid %b late %0d drive %b want 1/0/%b", i, result_valid, late_count, path_drive, drv0);
            end
        end
        start = 1'b0;
        do_accept();
        n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_accept: valid %b busy %b want 0/0", result_valid, busy); end
    endtask

    task automatic test_reset_midrun();
        int s, cyc, tog, lm, fm;
        bit to;
        chain_dly = 14; stuck_en = 1'b0;
        s = $urandom_range(0, 4);
        model_trials(3, s, 14, 1'b0, 1'b0, drv_model, lm, fm);
        @(negedge clk);
        trials = TRIALS_W'(10); settle_cycles = SETTLE_W'(s); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3 * (3 + s)) @(posedge clk);
        #1;
        n_cmp++; if (late_count !== CNT_W'(lm) || busy !== 1'b1) begin n_bad++; $display("FAIL midrun_pre: late %0d busy %b want %0d/1", late_count, busy, lm); end
        n_cmp++; if (path_drive !== ~drv_model) begin n_bad++; $display("FAIL midrun_drive_pre: got %b want %b", path_drive, ~drv_model); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_state: busy %b valid %b want 0/0", busy, result_valid); end
        n_cmp++; if (path_drive !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_drive: got %b want 0", path_drive); end
        n_cmp++; if (late_count !== '0) begin n_bad++; $display("FAIL midrun_rst_late: got %0d want 0", late_count); end
        @(negedge clk);
        rst = 1'b0;
        drv_model   = 1'b0;
        s_drv_model = 1'b0;
        repeat (3) @(posedge clk);
        model_trials(10, s, 14, 1'b0, 1'b0, drv_model, lm, fm);
        do_run(10, s, cyc, tog, to);
        n_cmp++; if (to || cyc != 10 * (3 + s)) begin n_bad++; $display("FAIL midrun_rerun_latency: got %0d want %0d", cyc, 10 * (3 + s)); end
        n_cmp++; if (late_count !== CNT_W'(lm) || tog != 10) begin n_bad++; $display("FAIL midrun_rerun: late %0d toggles %0d want %0d/10", late_count, tog, lm); end
        do_accept();
    endtask

    task automatic test_random();
        int n, s, d, cyc, tog, lm, fm, ef;
        bit to, stk, sv, chk;
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(1, 12);
            s   = $urandom_range(0, 5);
            stk = ($urandom_range(0, 3) == 0);
            sv  = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : int'($urandom_range(11, 19));
            chain_dly = d; stuck_en = stk; stuck_val = sv;
            model_trials(n, s, d, stk, sv, drv_model, lm, fm);
            fault_expect(s, fm, 65535, chk, ef);
            do_run(n, s, cyc, tog, to);
            drv_model = drv_model ^ n[0];
            n_cmp++; if (to || cyc != n * (3 + s)) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d (n=%0d s=%0d)", it, cyc, n * (3 + s), n, s); end
            n_cmp++; if (late_count !== CNT_W'(lm)) begin n_bad++; $display("FAIL rand%0d_late: got %0d want %0d (n=%0d s=%0d d=%0d stuck=%b/%b)", it, late_count, lm, n, s, d, stk, sv); end
            n_cmp++; if (tog != n) begin n_bad++; $display("FAIL rand%0d_toggles: got %0d want %0d", it, tog, n); end
            n_cmp++; if (path_drive !== drv_model) begin n_bad++; $display("FAIL rand%0d_drive_level: got %b want %b", it, path_drive, drv_model); end
            if (chk) begin
                n_cmp++; if (fault_count !== CNT_W'(ef)) begin n_bad++; $display("FAIL rand%0d_fault: got %0d want %0d", it, fault_count, ef); end
            end
            do_accept();
            n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_accept: valid %b want 0", it, result_valid); end
        end
        stuck_en = 1'b0;
    endtask

    task automatic test_saturation();
        int s, cyc, lm, fm, el, ef;
        bit to, chk;
        s = $urandom_range(0, 3);
        model_trials(7, s, 14, 1'b0, 1'b0, s_drv_model, lm, fm);
        el = sat(lm, 3);
        fault_expect(s, fm, 3, chk, ef);
        @(negedge clk);
        s_trials = 3'd7; s_settle = SETTLE_W'(s); s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        n_cmp++; if (to || cyc != 7 * (3 + s)) begin n_bad++; $display("FAIL sat_latency: got %0d want %0d", cyc, 7 * (3 + s)); end
        n_cmp++; if (s_late !== S_CNT_W'(el)) begin n_bad++; $display("FAIL sat_late: got %0d want %0d", s_late, el); end
        if (chk) begin
            n_cmp++; if (s_fault !== S_CNT_W'(ef)) begin n_bad++; $display("FAIL sat_fault: got %0d want %0d", s_fault, ef); end
        end
        @(negedge clk);
        s_ready = 1'b1;
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        n_cmp++; if (s_valid !== 1'b0 || s_late !== S_CNT_W'(el)) begin n_bad++; $display("FAIL sat_accept: valid %b late %0d want 0/%0d", s_valid, s_late, el); end
    endtask

    initial begin
        test_reset();
        test_fast_chain();
        test_slow_chain();
        test_stuck();
        test_zero_trials();
        test_reset_midrun();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
